// File: rtl/spi_slave.sv
// SPI mode-0 slave endpoint: synchronises SCLK/SS/MOSI into clk, deserialises MOSI
// into rx_data with a valid/ack handshake and serialises a preloaded word onto MISO.
// state   | meaning
// S_IDLE  | synchronised SS high, waiting for SS fall
// S_SHIFT | transaction active, shifting on synchronised SCLK edges
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_empty,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d;
    logic [CW-1:0]          r_bit_cnt;
    logic [WIDTH-1:0]       r_rx_shift, r_tx_shift, r_tx_hold;
    logic                   r_reload_pend, r_done;

    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic w_start, w_abort, w_active, w_rise_act, w_fall_act, w_boundary, w_reload;

    // SS synchroniser resets high so an idle bus never looks like a select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;
    assign busy        = ~w_ss_s;

    assign w_start    = (r_state == S_IDLE) && w_ss_fall;
    assign w_abort    = (r_state == S_SHIFT) && w_ss_rise;
    assign w_active   = (r_state == S_SHIFT) && !w_ss_rise;
    assign w_rise_act = w_active && w_sclk_rise;
    assign w_fall_act = w_active && w_sclk_fall;
    assign w_boundary = w_rise_act && (r_bit_cnt == CW'(WIDTH-1));
    assign w_reload   = w_start || (w_fall_act && r_reload_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ss_fall) w_next = S_SHIFT;
            S_SHIFT: if (w_ss_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        miso_oe = (r_state == S_SHIFT);
        MISO    = miso_oe ? r_tx_shift[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_reload_pend <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_boundary;
            if (w_start || w_abort) begin
                r_bit_cnt     <= '0;
                r_reload_pend <= 1'b0;
            end else if (w_rise_act) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
                r_bit_cnt  <= w_boundary ? '0 : r_bit_cnt + CW'(1);
                if (w_boundary) r_reload_pend <= 1'b1;
            end else if (w_fall_act && r_reload_pend) begin
                r_reload_pend <= 1'b0;
            end
        end
    end

    // A load coinciding with a reload bypasses straight into the shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_hold  <= '0;
            r_tx_shift <= '0;
            tx_empty   <= 1'b1;
        end else begin
            if (tx_load) r_tx_hold <= tx_data;
            if (w_reload) begin
                r_tx_shift <= tx_load ? tx_data : r_tx_hold;
                tx_empty   <= 1'b1;
            end else begin
                if (w_fall_act) r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                if (tx_load)    tx_empty   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (r_done) begin
            rx_data  <= r_rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ack) overrun <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table of single-word transfers, scoreboard of
// expected rx words, and hand-written sequences for boundary, abort, overrun and reset.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, SCLK, SS, MOSI, MISO, miso_oe;
    logic [7:0] tx_data, rx_data;
    logic       tx_load, tx_empty, rx_valid, rx_ack, overrun, busy;
    logic       auto_ack, man_ack, mon_en, mon_prev;
    int         checks = 0, errors = 0, rx_events = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .overrun(overrun), .busy(busy)
    );

    assign rx_ack = (auto_ack & rx_valid) | man_ack;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each new rx_valid assertion pops one expected word
    always @(negedge clk) begin
        if (mon_en && rx_valid && !mon_prev) begin
            rx_events++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no word at %0t", rx_data, $time);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
            end
        end
        mon_prev = rx_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ss_low();
        SS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge clk);
        SS = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic m);
        MOSI = b;
        repeat (4) @(negedge clk);
        m = MISO;
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, output logic [7:0] m);
        for (int i = 7; i >= 0; i--) send_bit(w[i], m[i]);
    endtask

    initial begin
        logic [7:0] m0, m1;
        logic       mb;
        int         ev0;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{8'h81, 8'h7E, 8'h81, 8'h7E};

        SCLK = 0; SS = 1; MOSI = 0; tx_data = 0; tx_load = 0;
        man_ack = 0; auto_ack = 1; mon_en = 1; mon_prev = 0; rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);

        chk("rst_miso", 32'(MISO), 0);
        chk("rst_miso_oe", 32'(miso_oe), 0);
        chk("rst_tx_empty", 32'(tx_empty), 1);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].tx);
            chk("tx_empty_loaded", 32'(tx_empty), 0);
            ss_low();
            chk("tx_empty_after_fall", 32'(tx_empty), 1);
            chk("busy_active", 32'(busy), 1);
            chk("miso_oe_active", 32'(miso_oe), 1);
            sb_q.push_back(vecs[i].exp_rx);
            send_word(vecs[i].mosi, m0);
            ss_high();
            chk("vec_miso", 32'(m0), 32'(vecs[i].exp_miso));
            chk("busy_idle", 32'(busy), 0);
        end

        // Back-to-back words with ack; holding register empty so the word repeats
        ev0 = rx_events;
        load(8'h55);
        ss_low();
        sb_q.push_back(8'h01);
        send_word(8'h01, m0);
        sb_q.push_back(8'h02);
        send_word(8'h02, m1);
        ss_high();
        chk("b2b_events", 32'(rx_events - ev0), 2);
        chk("b2b_overrun", 32'(overrun), 0);
        chk("b2b_miso0", 32'(m0), 32'h55);
        chk("b2b_retransmit", 32'(m1), 32'h55);

        // tx_load exactly in the reload cycle bypasses into the shifter
        load(8'h3C);
        ss_low();
        sb_q.push_back(8'hAA);
        send_word(8'hAA, m0);
        repeat (2) @(negedge clk);
        tx_data = 8'hC3;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        chk("bypass_tx_empty", 32'(tx_empty), 1);
        sb_q.push_back(8'h55);
        send_word(8'h55, m1);
        ss_high();
        chk("bypass_miso0", 32'(m0), 32'h3C);
        chk("bypass_miso1", 32'(m1), 32'hC3);
        chk("bypass_tx_empty_end", 32'(tx_empty), 1);

        // Abort after 5 bits: partial word must never surface
        ev0 = rx_events;
        load(8'h96);
        ss_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1, mb);
        ss_high();
        chk("abort_miso_oe", 32'(miso_oe), 0);
        chk("abort_rx_valid", 32'(rx_valid), 0);
        chk("abort_tx_empty", 32'(tx_empty), 1);
        sb_q.push_back(8'h81);
        ss_low();
        send_word(8'h81, m0);
        ss_high();
        chk("abort_events", 32'(rx_events - ev0), 1);
        chk("abort_retransmit", 32'(m0), 32'h96);

        // Overrun: no ack between two words
        auto_ack = 0;
        mon_en = 0;
        ss_low();
        send_word(8'h01, m0);
        send_word(8'h02, m1);
        ss_high();
        chk("ovr_rx_data", 32'(rx_data), 32'h02);
        chk("ovr_rx_valid", 32'(rx_valid), 1);
        chk("ovr_overrun", 32'(overrun), 1);
        man_ack = 1;
        @(negedge clk);
        man_ack = 0;
        chk("ovr_ack_clears", 32'(rx_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        @(negedge clk);
        mon_en = 1;
        auto_ack = 1;

        // Reset in the middle of a word
        load(8'h11);
        ss_low();
        for (int i = 0; i < 3; i++) send_bit(1'b1, mb);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_miso", 32'(MISO), 0);
        chk("mid_rst_miso_oe", 32'(miso_oe), 0);
        chk("mid_rst_tx_empty", 32'(tx_empty), 1);
        chk("mid_rst_rx_data", 32'(rx_data), 0);
        chk("mid_rst_rx_valid", 32'(rx_valid), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        SS = 1;
        SCLK = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        load(8'hA5);
        sb_q.push_back(8'h5A);
        ss_low();
        send_word(8'h5A, m0);
        ss_high();
        chk("post_rst_miso", 32'(m0), 32'hA5);
        chk("post_rst_overrun", 32'(overrun), 0);

        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint, the receiving end of the SPI link that the team's SPI master drives.
- Protocol: mode 0 (CPOL=0, CPHA=0), MSB first, active-low SS.
- Samples the external SCLK, SS and MOSI into the local clk domain and deserialises MOSI into rx_data, delivered with a valid/ack handshake.
- Simultaneously serialises a preloaded tx word onto MISO (full duplex).

Parameters:
WIDTH, 8, bits per SPI word (≥2)
SYNC_STAGES, 2, flop stages on SCLK/SS/MOSI synchronisers (≥2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
SCLK  input  1  SPI clock from master (asynchronous to clk)
SS  input  1  slave select, active low
MOSI  input  1  master-out data
MISO  output  1  slave-out data
miso_oe  output  1  MISO drive enable; 1 while synchronised SS is low
tx_data  input  WIDTH  word to transmit
tx_load  input  1  1-cycle strobe; writes tx_data into the tx holding register
tx_empty  output  1  holding register consumed, ready for the next tx_load
rx_data  output  WIDTH  last received word
rx_valid  output  1  rx_data holds an unacknowledged word
rx_ack  input  1  consumer acknowledges rx_data
overrun  output  1  sticky: a word completed while rx_valid was still 1
busy  output  1  synchronised SS low (transaction in progress)

Behaviour:
- Reset values (asynchronous): MISO=0, miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, overrun=0, busy=0. Holding register, shift registers and bit counter are cleared; state=IDLE.
- Synchronisers:
  - SCLK, SS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last synchronised stage against one further registered copy.
  - Timing requirement: SCLK high and low phases each ≥3 clk periods; SS setup before the first SCLK rise ≥3 clk periods.
- States:
  - IDLE: synchronised SS high. A detected SS fall goes to SHIFT, clears the bit counter, copies the holding register to tx_shift and sets tx_empty=1.
  - SHIFT:
    - On each synchronised SCLK rise: rx_shift <= {rx_shift[WIDTH-2:0], MOSI_sync}; bit counter +1.
    - On each synchronised SCLK fall: tx_shift shifts left, zero-filled.
    - Word boundary (rise where counter = WIDTH-1): counter wraps to 0; the completed word is presented next cycle; at the following SCLK fall tx_shift reloads from the holding register (tx_empty<=1) instead of shifting.
    - A detected SS rise goes to IDLE from any counter value.
- MISO = tx_shift[WIDTH-1] while miso_oe=1, else 0. The first bit is valid from the cycle after the SS fall is detected.
- RX delivery:
  - One cycle after the boundary rise: rx_data <= completed word, rx_valid <= 1.
  - If rx_valid was already 1 and no rx_ack arrives in that cycle: rx_data is overwritten and overrun <= 1.
  - rx_ack clears rx_valid the next cycle.
  - rx_ack in the same cycle as a new completion: rx_valid stays 1 with the new word; no overrun.
- overrun clears only on rst.
- TX holding register:
  - tx_load writes it and sets tx_empty=0 at any time.
  - tx_load in the same cycle as a reload/SS-fall copy: tx_data bypasses directly into tx_shift, the holding register is also written, and tx_empty ends at 1.
  - Empty at reload: the previous holding value is retransmitted.
- Mid-word SS rise (abort): partial rx bits are discarded, no rx_valid, counter cleared, MISO=0 / miso_oe=0 next cycle, holding register unchanged.
- Reset mid-transaction returns immediately to reset values; the next word needs a fresh SS fall.
- busy = NOT SS_sync. SCLK edges while SS_sync is high are ignored.

Test Plan:
- Reset, tx_load tx_data=8'hA5. SS low, master sends 8'h3C at SCLK=clk/8 → MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1 one cycle after the 8th synchronised rise; tx_empty=1 after the SS fall.
- Two back-to-back words 8'h01, 8'h02 without SS deasserting; rx_ack after each → two rx_valid events, rx_data 01 then 02, overrun=0.
- Same two words with no rx_ack → rx_data=8'h02, rx_valid=1, overrun=1, and overrun stays 1 after a later rx_ack.
- SS rise after 5 SCLK rises of 8'hFF, then a full word 8'h81 → only one rx_valid, rx_data=8'h81; the partial word never appears.
- tx_load 8'hC3 in the exact cycle of the word-boundary reload → the second word's MISO = 8'hC3 and tx_empty=1 afterwards. With no tx_load, the second word retransmits the prior holding value.
- Assert rst mid-word → all outputs return to reset values within the same cycle; a subsequent full transaction of 8'h5A is received correctly.
